// File: rtl/regbank_read_port_if.sv
// Handshake bundle between the operand read port, its requester and the ALU.
// master drives selects and op_ready; slave (the read port) returns the operands.
interface regbank_read_port_if #(
    parameter int WIDTH = 16,
    parameter int AW    = 4
);
    logic             req_valid;
    logic             req_ready;
    logic [AW-1:0]    req_sel_a;
    logic [AW-1:0]    req_sel_b;
    logic             op_valid;
    logic             op_ready;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;

    modport master (
        output req_valid, req_sel_a, req_sel_b, op_ready,
        input  req_ready, op_valid, op_a, op_b
    );

    modport slave (
        input  req_valid, req_sel_a, req_sel_b, op_ready,
        output req_ready, op_valid, op_a, op_b
    );
endinterface

// File: rtl/regbank_read_port.sv
// Two-operand read port of the register bank with same-cycle write bypass and a
// 2-entry (head + skid) output buffer toward the ALU.
module regbank_read_port_lane #(
    parameter int WIDTH = 16
) (
    input  logic             wr_en_bit,
    input  logic [WIDTH-1:0] wr_bus,
    input  logic [WIDTH-1:0] reg_val,
    output logic [WIDTH-1:0] val
);
    assign val = wr_en_bit ? wr_bus : reg_val;
endmodule

module regbank_read_port #(
    parameter int WIDTH = 16,
    parameter int NREGS = 16,
    parameter int AW    = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [WIDTH*NREGS-1:0] reg_flat,
    input  logic [WIDTH-1:0]       wr_bus,
    input  logic [NREGS-1:0]       wr_en,
    regbank_read_port_if.slave     rp,
    output logic                   onehot_err
);
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    logic [NREGS-1:0][WIDTH-1:0] byp;
    logic [1:0]       state, state_nxt;
    logic             req_ready_q;
    logic [WIDTH-1:0] head_a, head_b, skid_a, skid_b;
    logic [WIDTH-1:0] cap_a, cap_b;
    logic             accept, pop, multi_wr;

    // Each register's view for this cycle already includes a pending write.
    for (genvar i = 0; i < NREGS; i++) begin : g_lane
        regbank_read_port_lane #(.WIDTH(WIDTH)) u_lane (
            .wr_en_bit (wr_en[i]),
            .wr_bus    (wr_bus),
            .reg_val   (reg_flat[i*WIDTH +: WIDTH]),
            .val       (byp[i])
        );
    end

    assign cap_a    = byp[rp.req_sel_a];
    assign cap_b    = byp[rp.req_sel_b];
    assign accept   = rp.req_valid && req_ready_q;
    assign pop      = rp.op_valid && rp.op_ready;
    assign multi_wr = |(wr_en & (wr_en - NREGS'(1)));

    always_comb begin
        state_nxt = state;
        case (state)
            ST_EMPTY: if (accept) state_nxt = ST_ONE;
            ST_ONE: begin
                if (accept && !pop)      state_nxt = ST_FULL;
                else if (pop && !accept) state_nxt = ST_EMPTY;
            end
            ST_FULL:  if (pop) state_nxt = ST_ONE;
            default:  state_nxt = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_EMPTY;
            req_ready_q <= 1'b1;
            head_a      <= '0;
            head_b      <= '0;
            skid_a      <= '0;
            skid_b      <= '0;
            onehot_err  <= 1'b0;
        end else begin
            state       <= state_nxt;
            // Registered from the next state so op_ready never reaches req_ready combinationally.
            req_ready_q <= (state_nxt != ST_FULL);
            if (accept && (state == ST_EMPTY || pop)) begin
                head_a <= cap_a;
                head_b <= cap_b;
            end else if (state == ST_FULL && pop) begin
                head_a <= skid_a;
                head_b <= skid_b;
            end
            if (accept && state == ST_ONE && !pop) begin
                skid_a <= cap_a;
                skid_b <= cap_b;
            end
            if (multi_wr) onehot_err <= 1'b1;
        end
    end

    assign rp.req_ready = req_ready_q;
    assign rp.op_valid  = (state != ST_EMPTY);
    assign rp.op_a      = head_a;
    assign rp.op_b      = head_b;
endmodule

// File: tb/tb_regbank_read_port.sv
// Scoreboard bench for regbank_read_port: expected pairs are queued on accept
// and compared against the head while op_valid is high.
module tb_regbank_read_port;
    localparam int WIDTH = 16;
    localparam int NREGS = 16;
    localparam int AW    = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic [WIDTH*NREGS-1:0] reg_flat;
    logic [WIDTH-1:0]       wr_bus;
    logic [NREGS-1:0]       wr_en;
    logic                   onehot_err;
    logic [WIDTH-1:0]       bank [NREGS];

    int n_chk  = 0;
    int n_fail = 0;
    logic [31:0] sb_q [$];

    regbank_read_port_if #(.WIDTH(WIDTH), .AW(AW)) rp ();

    regbank_read_port #(.WIDTH(WIDTH), .NREGS(NREGS), .AW(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .reg_flat   (reg_flat),
        .wr_bus     (wr_bus),
        .wr_en      (wr_en),
        .rp         (rp),
        .onehot_err (onehot_err)
    );

    always #5 clk = ~clk;

    function automatic logic [WIDTH-1:0] init_val(input int i);
        if (i == 3) return 16'h1234;
        if (i == 9) return 16'hBEEF;
        return 16'(16'h0A00 + i * 16'h0111);
    endfunction

    // Bank model: reloads while reset is low, otherwise applies every enabled write.
    always @(posedge clk) begin
        for (int i = 0; i < NREGS; i++) begin
            if (!reset)        bank[i] <= init_val(i);
            else if (wr_en[i]) bank[i] <= wr_bus;
        end
    end

    always_comb begin
        reg_flat = '0;
        for (int i = 0; i < NREGS; i++) reg_flat[i*WIDTH +: WIDTH] = bank[i];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] expect_pair(input logic [AW-1:0] sa, input logic [AW-1:0] sb);
        logic [WIDTH-1:0] a, b;
        a = wr_en[sa] ? wr_bus : bank[sa];
        b = wr_en[sb] ? wr_bus : bank[sb];
        return {a, b};
    endfunction

    always @(negedge clk) begin
        if (reset) begin
            if (rp.op_valid) begin
                if (sb_q.size() == 0) chk("op_unexpected", 32'(rp.op_valid), 32'd0);
                else begin
                    chk("op_pair", {rp.op_a, rp.op_b}, sb_q[0]);
                    if (rp.op_ready) void'(sb_q.pop_front());
                end
            end
            if (rp.req_valid && rp.req_ready)
                sb_q.push_back(expect_pair(rp.req_sel_a, rp.req_sel_b));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic [AW-1:0] sa, input logic [AW-1:0] sb);
        rp.req_valid = 1'b1;
        rp.req_sel_a = sa;
        rp.req_sel_b = sb;
    endtask

    initial begin
        rp.req_valid = 1'b0;
        rp.req_sel_a = '0;
        rp.req_sel_b = '0;
        rp.op_ready  = 1'b0;
        wr_en        = '0;
        wr_bus       = '0;
        #2 reset = 1'b0;
        #1;
        chk("rst_op_valid",  32'(rp.op_valid),  32'd0);
        chk("rst_op_ab",     {rp.op_a, rp.op_b}, 32'd0);
        chk("rst_req_ready", 32'(rp.req_ready), 32'd1);
        chk("rst_err",       32'(onehot_err),   32'd0);
        repeat (3) cyc();
        reset = 1'b1;

        // Basic read, one-cycle latency.
        req(4'd3, 4'd9);
        rp.op_ready = 1'b1;
        cyc();
        chk("t1_valid", 32'(rp.op_valid), 32'd1);
        chk("t1_ab", {rp.op_a, rp.op_b}, {16'h1234, 16'hBEEF});

        // Same-cycle write bypass.
        wr_en = 16'h0008; wr_bus = 16'hAAAA;
        req(4'd3, 4'd3);
        cyc();
        chk("t2_bypass_same", {rp.op_a, rp.op_b}, {16'hAAAA, 16'hAAAA});
        wr_bus = 16'h5555;
        req(4'd3, 4'd4);
        cyc();
        chk("t2_bypass_old_r4", {rp.op_a, rp.op_b}, {16'h5555, init_val(4)});
        wr_en = '0;
        rp.req_valid = 1'b0;
        cyc();

        // Back-pressure fills the buffer.
        rp.op_ready = 1'b0;
        req(4'd1, 4'd2);
        cyc();
        chk("t3_ready_one", 32'(rp.req_ready), 32'd1);
        req(4'd5, 4'd6);
        cyc();
        chk("t3_ready_full", 32'(rp.req_ready), 32'd0);
        req(4'd7, 4'd8);
        cyc();
        chk("t3_ready_hold", 32'(rp.req_ready), 32'd0);
        chk("t3_head_stable", {rp.op_a, rp.op_b}, {init_val(1), init_val(2)});
        rp.op_ready = 1'b1;
        cyc();
        chk("t3_pair2", {rp.op_a, rp.op_b}, {init_val(5), init_val(6)});
        cyc();
        rp.req_valid = 1'b0;
        chk("t3_pair3", {rp.op_a, rp.op_b}, {init_val(7), init_val(8)});
        cyc();
        chk("t3_drained_valid", 32'(rp.op_valid), 32'd0);
        chk("t3_drained_sb", 32'(sb_q.size()), 32'd0);

        // Toggling op_ready with continuous requests and occasional writes.
        for (int i = 0; i < 20; i++) begin
            rp.op_ready = i[0];
            req(AW'($urandom_range(0, NREGS-1)), AW'($urandom_range(0, NREGS-1)));
            wr_bus = 16'($urandom);
            wr_en  = ($urandom_range(0, 2) == 0) ? NREGS'(1) << $urandom_range(0, NREGS-1) : '0;
            cyc();
        end
        rp.req_valid = 1'b0;
        wr_en = '0;
        rp.op_ready = 1'b1;
        repeat (4) cyc();
        chk("t4_drained_sb", 32'(sb_q.size()), 32'd0);

        // Async reset while FULL.
        rp.op_ready = 1'b0;
        req(4'd10, 4'd11);
        cyc();
        req(4'd12, 4'd13);
        cyc();
        chk("t5_full", 32'(rp.req_ready), 32'd0);
        #1 reset = 1'b0;
        #1;
        chk("t5_async_valid", 32'(rp.op_valid), 32'd0);
        chk("t5_async_ab", {rp.op_a, rp.op_b}, 32'd0);
        sb_q.delete();
        rp.req_valid = 1'b0;
        cyc();
        cyc();
        reset = 1'b1;
        cyc();
        chk("t5_ready_release", 32'(rp.req_ready), 32'd1);
        chk("t5_no_stale", 32'(rp.op_valid), 32'd0);

        // Multi-hot write enable: sticky error, bypass still applies.
        chk("t6_err_clear", 32'(onehot_err), 32'd0);
        rp.op_ready = 1'b1;
        wr_en = 16'h0011; wr_bus = 16'hC0DE;
        req(4'd0, 4'd4);
        cyc();
        wr_en = '0;
        rp.req_valid = 1'b0;
        chk("t6_err_set", 32'(onehot_err), 32'd1);
        chk("t6_bypass", {rp.op_a, rp.op_b}, {16'hC0DE, 16'hC0DE});
        repeat (3) cyc();
        chk("t6_err_sticky", 32'(onehot_err), 32'd1);
        reset = 1'b0;
        #1;
        chk("t6_err_reset", 32'(onehot_err), 32'd0);
        cyc();
        reset = 1'b1;
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
